mips_multicycle_sequencer: RTL and testbench
============================================

# mips_multicycle_sequencer

Multicycle control sequencer for the MIPS datapath: the ALU, register file, sign-extender and data RAM, with the PC and instruction register outside this block. It replaces the single-cycle combinational `control` decode with a Fetch/Decode/Execute/Memory/Writeback state machine. Each instruction is stepped through the shared datapath over 2–5+ cycles. Memory accesses use a req/ack handshake, so the block tolerates variable-latency instruction and data memories.

## Interface
Parameters:
- MEM_TIMEOUT, 16: cycles a memory request may wait for ack before trapping. Used only with SEQ_MEM_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag (status[7])
- imem_ack  in  1  instruction memory data valid
- dmem_ack  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- dmem_we  out  1  data write enable; qualified by dmem_req
- ir_load  out  1  load the instruction register
- pc_write  out  1  update the PC
- pc_src  out  2  00 = PC+4, 01 = branch target, 10 = jump target
- alu_src  out  1  0 = rt data, 1 = sign-extended immediate
- alu_ctrl  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
- reg_dst  out  1  1 = rd, 0 = rt
- mem2reg  out  1  1 = RAM data to register file
- reg_write  out  1  register file write enable
- instr_done  out  1  one-cycle pulse on an instruction's final cycle
- exception  out  1  one-cycle pulse on entering TRAP
- exc_cause  out  2  00 none, 01 illegal opcode, 10 illegal funct, 11 memory timeout; held in TRAP
- halted  out  1  high while in TRAP

## Operation
- States:
  - FETCH: assert imem_req. On imem_ack, pulse ir_load and pc_write with pc_src = 00, then go to DECODE.
  - DECODE: latch the instruction class from opcode/funct.
    - j (0x02): pc_write with pc_src = 10, instr_done, go to FETCH.
    - Supported opcodes are 0x00, 0x08, 0x23, 0x2B, 0x04; any other opcode goes to TRAP with cause 01.
    - Opcode 0x00 with a funct other than 0x20/22/24/25/2A goes to TRAP with cause 10.
    - Otherwise go to EXEC.
  - EXEC:
    - R-type: alu_src = 0, alu_ctrl from funct; go to WB.
    - addi/lw/sw: alu_src = 1, alu_ctrl = 0010; addi goes to WB, lw/sw go to MEM.
    - beq: alu_src = 0, alu_ctrl = 0110. If zero, pc_write with pc_src = 01. Then instr_done and go to FETCH.
  - MEM: assert dmem_req; dmem_we = 1 for sw. On dmem_ack, lw goes to WB; sw pulses instr_done and goes to FETCH.
  - WB: reg_write = 1; reg_dst = 1 for R-type; mem2reg = 1 for lw. Pulse instr_done and go to FETCH.
  - TRAP: terminal until reset. All enables are 0, halted = 1, exc_cause is held.
- ALU and mux selects are held stable from EXEC through WB for the same instruction, so the datapath result stays valid at writeback.
- All outputs are combinational from the registered state, the latched class and the ack inputs. Output glitches are tolerated because every enable is sampled on clk.

## Timing
- Reset values: while rst_n = 0 at a clock edge, the block goes to FETCH with the class cleared, the timeout counter at 0, exc_cause = 00 and halted = 0. All outputs are 0 while rst_n is low.
- First imem_req is asserted in the first cycle after rst_n rises.
- Reset mid-instruction, including inside TRAP, aborts with no further enables asserted.
- Latency with zero-wait memories (ack in the same cycle as req):
  - j: 2 cycles
  - beq: 3 cycles
  - R-type, addi, sw: 4 cycles
  - lw: 5 cycles
  - Each memory wait cycle adds 1.
- Handshake rules:
  - req stays high until ack is sampled high.
  - An ack arriving while no req is asserted is ignored.
  - dmem_we never asserts outside MEM.
- A beq with zero = 0 still pulses instr_done and does not write the PC.

## Configuration
- SEQ_MEM_TIMEOUT_EN defined:
  - A counter increments on each FETCH or MEM cycle without ack and clears on ack or state exit.
  - When the count reaches MEM_TIMEOUT, the block goes to TRAP with cause 11.
  - If ack and the limit occur in the same cycle, ack wins.
- SEQ_MEM_TIMEOUT_EN undefined: no counter is built, the block waits indefinitely, and cause 11 is never produced.

## Test plan
- Reset, then addi (opcode 0x08) with an immediate ack → imem_req in cycle 1; reg_write with alu_src = 1 and alu_ctrl = 0010 in cycle 4; instr_done in cycle 4.
- lw with dmem_ack delayed 3 cycles → dmem_req held 4 cycles with dmem_we = 0; WB has mem2reg = 1 and reg_dst = 0; total 8 cycles.
- beq with zero = 1, then beq with zero = 0 → first: pc_write with pc_src = 01 in EXEC; second: no pc_write; 3 cycles each.
- Opcode 0x3F, then reset → exception pulse, exc_cause = 01, halted = 1; after rst_n low for 1 cycle, halted = 0 and a fetch restarts.
- R-type with funct 0x22, then funct 0x01 → alu_ctrl = 0110 with reg_dst = 1; then TRAP with cause 10.
- With SEQ_MEM_TIMEOUT_EN and MEM_TIMEOUT = 4, imem_ack held low → TRAP with cause 11 after 4 FETCH cycles; an ack on the 4th cycle instead proceeds to DECODE.

Source files
------------

// File: rtl/mips_multicycle_sequencer.sv
// mips_multicycle_sequencer
//   Multicycle control sequencer for the MIPS datapath. Walks each instruction
//   through FETCH / DECODE / EXEC / MEM / WB over the shared ALU, register file
//   and data RAM. Instruction and data memories are reached through req/ack
//   handshakes, so either one may take any number of cycles to respond.
//
// Parameters
//   MEM_TIMEOUT  cycles a memory request may wait for ack before trapping
//                (only has an effect when SEQ_MEM_TIMEOUT_EN is defined)
//
// Optional feature
//   `define SEQ_MEM_TIMEOUT_EN  builds the memory wait watchdog (trap cause 11).
//   Without it no counter exists and the block waits indefinitely.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   opcode, funct     IR fields (valid from DECODE onward)
//   zero              ALU zero flag, used for beq
//   imem_ack/dmem_ack memory handshake acknowledges
//   imem_req          instruction fetch request
//   dmem_req/dmem_we  data memory request / write enable
//   ir_load, pc_write, pc_src      IR / PC controls
//   alu_src, alu_ctrl, reg_dst, mem2reg, reg_write   datapath controls
//   instr_done        pulse on an instruction's final cycle
//   exception         pulse on the first TRAP cycle
//   exc_cause         00 none, 01 bad opcode, 10 bad funct, 11 memory timeout
//   halted            high while in TRAP
module mips_multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_load,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src,
  output logic [3:0] alu_ctrl,
  output logic       reg_dst,
  output logic       mem2reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       exception,
  output logic [1:0] exc_cause,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_RTYPE, C_ADDI, C_LW, C_SW, C_BEQ
  } cls_t;

  state_t     state, state_nx;
  cls_t       cls, cls_nx;
  logic [3:0] alu_op, alu_op_nx;
  logic [1:0] cause, cause_nx;
  logic       exc_q, exc_nx;
  logic       timeout_hit;

  // ---------------------------------------------------------------- decode
  cls_t       dec_cls;
  logic [3:0] dec_alu;
  logic       dec_jump, dec_bad_op, dec_bad_fn;

  always_comb begin
    dec_cls    = C_NONE;
    dec_alu    = 4'b0010;
    dec_jump   = 1'b0;
    dec_bad_op = 1'b0;
    dec_bad_fn = 1'b0;
    case (opcode)
      6'h00: begin
        dec_cls = C_RTYPE;
        case (funct)
          6'h20:   dec_alu = 4'b0010;
          6'h22:   dec_alu = 4'b0110;
          6'h24:   dec_alu = 4'b0000;
          6'h25:   dec_alu = 4'b0001;
          6'h2A:   dec_alu = 4'b0111;
          default: begin
            dec_bad_fn = 1'b1;
            dec_cls    = C_NONE;
          end
        endcase
      end
      6'h02:   dec_jump = 1'b1;
      6'h08:   dec_cls  = C_ADDI;
      6'h23:   dec_cls  = C_LW;
      6'h2B:   dec_cls  = C_SW;
      6'h04: begin
        dec_cls = C_BEQ;
        dec_alu = 4'b0110;
      end
      default: dec_bad_op = 1'b1;
    endcase
  end

  // ------------------------------------------------------- memory watchdog
`ifdef SEQ_MEM_TIMEOUT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] to_cnt;
  logic          waiting;

  assign waiting     = ((state == S_FETCH) && !imem_ack) ||
                       ((state == S_MEM)   && !dmem_ack);
  // Fires on the MEM_TIMEOUT-th consecutive wait cycle; an ack in that same
  // cycle clears waiting, so ack takes priority.
  assign timeout_hit = waiting && (to_cnt == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)                            to_cnt <= '0;
    else if (waiting && state_nx == state) to_cnt <= to_cnt + 1'b1;
    else                                   to_cnt <= '0;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (MEM_TIMEOUT > 0);
  assign timeout_hit        = 1'b0;
`endif

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      cls    <= C_NONE;
      alu_op <= 4'b0000;
      cause  <= 2'b00;
      exc_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      cls    <= cls_nx;
      alu_op <= alu_op_nx;
      cause  <= cause_nx;
      exc_q  <= exc_nx;
    end
  end

  logic       imem_req_c, dmem_req_c, dmem_we_c, ir_load_c, pc_write_c;
  logic       reg_write_c, done_c, sel_en;
  logic [1:0] pc_src_c;

  always_comb begin
    state_nx    = state;
    cls_nx      = cls;
    alu_op_nx   = alu_op;
    cause_nx    = cause;
    exc_nx      = 1'b0;
    imem_req_c  = 1'b0;
    dmem_req_c  = 1'b0;
    dmem_we_c   = 1'b0;
    ir_load_c   = 1'b0;
    pc_write_c  = 1'b0;
    pc_src_c    = 2'b00;
    reg_write_c = 1'b0;
    done_c      = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ack) begin
          ir_load_c  = 1'b1;
          pc_write_c = 1'b1;
          state_nx   = S_DECODE;
        end else if (timeout_hit) begin
          state_nx = S_TRAP;
          cause_nx = 2'b11;
          exc_nx   = 1'b1;
        end
      end
      S_DECODE: begin
        cls_nx    = dec_cls;
        alu_op_nx = dec_alu;
        if (dec_jump) begin
          pc_write_c = 1'b1;
          pc_src_c   = 2'b10;
          done_c     = 1'b1;
          state_nx   = S_FETCH;
        end else if (dec_bad_op) begin
          state_nx = S_TRAP;
          cause_nx = 2'b01;
          exc_nx   = 1'b1;
        end else if (dec_bad_fn) begin
          state_nx = S_TRAP;
          cause_nx = 2'b10;
          exc_nx   = 1'b1;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          C_BEQ: begin
            if (zero) begin
              pc_write_c = 1'b1;
              pc_src_c   = 2'b01;
            end
            done_c   = 1'b1;
            state_nx = S_FETCH;
          end
          C_LW, C_SW: state_nx = S_MEM;
          default:    state_nx = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (cls == C_SW);
        if (dmem_ack) begin
          if (cls == C_SW) begin
            done_c   = 1'b1;
            state_nx = S_FETCH;
          end else begin
            state_nx = S_WB;
          end
        end else if (timeout_hit) begin
          state_nx = S_TRAP;
          cause_nx = 2'b11;
          exc_nx   = 1'b1;
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_nx    = S_FETCH;
      end
      S_TRAP:  state_nx = S_TRAP;
      default: state_nx = S_FETCH;
    endcase
  end

  // Datapath selects come only from the latched class, so they hold steady
  // from EXEC through WB and the ALU result is still valid at writeback.
  assign sel_en = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

  // Every output is forced low while reset is asserted, before the edge lands.
  assign imem_req   = rst_n & imem_req_c;
  assign dmem_req   = rst_n & dmem_req_c;
  assign dmem_we    = rst_n & dmem_we_c;
  assign ir_load    = rst_n & ir_load_c;
  assign pc_write   = rst_n & pc_write_c;
  assign pc_src     = rst_n ? pc_src_c : 2'b00;
  assign alu_src    = rst_n & sel_en & ((cls == C_ADDI) || (cls == C_LW) || (cls == C_SW));
  assign alu_ctrl   = (rst_n && sel_en) ? alu_op : 4'b0000;
  assign reg_dst    = rst_n & sel_en & (cls == C_RTYPE);
  assign mem2reg    = rst_n & sel_en & (cls == C_LW);
  assign reg_write  = rst_n & reg_write_c;
  assign instr_done = rst_n & done_c;
  assign exception  = rst_n & exc_q;
  assign exc_cause  = rst_n ? cause : 2'b00;
  assign halted     = rst_n & (state == S_TRAP);

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// Bench for mips_multicycle_sequencer. A trace model lists, per instruction,
// the exact output vector expected on each cycle given the memory waits; the
// bench plays a memory responder and compares every cycle against that list.
module tb_mips_multicycle_sequencer;

  localparam int TO = 4;

  typedef logic [19:0] ovec_t;
  localparam ovec_t IREQ   = 20'h80000;
  localparam ovec_t DREQ   = 20'h40000;
  localparam ovec_t DWE    = 20'h20000;
  localparam ovec_t IRL    = 20'h10000;
  localparam ovec_t PCW    = 20'h08000;
  localparam ovec_t ALUSRC = 20'h01000;
  localparam ovec_t RDST   = 20'h00080;
  localparam ovec_t M2R    = 20'h00040;
  localparam ovec_t RW     = 20'h00020;
  localparam ovec_t DONE   = 20'h00010;
  localparam ovec_t EXC    = 20'h00008;
  localparam ovec_t HALT   = 20'h00001;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_load, pc_write;
  logic [1:0] pc_src, exc_cause;
  logic       alu_src, reg_dst, mem2reg, reg_write, instr_done, exception, halted;
  logic [3:0] alu_ctrl;

  int n_chk = 0, n_fail = 0;
  ovec_t expq[$];
  ovec_t obs[$];

  mips_multicycle_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_load(ir_load),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src),
    .alu_ctrl(alu_ctrl), .reg_dst(reg_dst), .mem2reg(mem2reg),
    .reg_write(reg_write), .instr_done(instr_done), .exception(exception),
    .exc_cause(exc_cause), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic ovec_t snap();
    return {imem_req, dmem_req, dmem_we, ir_load, pc_write, pc_src, alu_src,
            alu_ctrl, reg_dst, mem2reg, reg_write, instr_done, exception,
            exc_cause, halted};
  endfunction

  function automatic ovec_t src(input logic [1:0] v);   return {5'b0, v, 13'b0};  endfunction
  function automatic ovec_t ctrl(input logic [3:0] v);  return {8'b0, v, 8'b0};   endfunction
  function automatic ovec_t cse(input logic [1:0] v);   return {17'b0, v, 1'b0};  endfunction

  // Datapath select pattern an instruction should show from EXEC to WB.
  function automatic ovec_t sels(input logic [5:0] op, input logic [5:0] fn);
    ovec_t s;
    logic [3:0] a;
    a = 4'b0010;
    if (op == 6'h04) a = 4'b0110;
    if (op == 6'h00)
      case (fn)
        6'h22:   a = 4'b0110;
        6'h24:   a = 4'b0000;
        6'h25:   a = 4'b0001;
        6'h2A:   a = 4'b0111;
        default: a = 4'b0010;
      endcase
    s = ctrl(a);
    if (op == 6'h08 || op == 6'h23 || op == 6'h2B) s |= ALUSRC;
    if (op == 6'h00) s |= RDST;
    if (op == 6'h23) s |= M2R;
    return s;
  endfunction

  function automatic void push_trap(input logic [1:0] c);
    expq.push_back(EXC | cse(c) | HALT);
    expq.push_back(cse(c) | HALT);
    expq.push_back(cse(c) | HALT);
  endfunction

  // Expected per-cycle trace for one instruction; iw/dw are the memory waits.
  function automatic void build(input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input int iw, input int dw);
    ovec_t s, w;
    expq.delete();
`ifdef SEQ_MEM_TIMEOUT_EN
    if (iw >= TO) begin
      repeat (TO) expq.push_back(IREQ);
      push_trap(2'b11);
      return;
    end
`endif
    repeat (iw) expq.push_back(IREQ);
    expq.push_back(IREQ | IRL | PCW);
    if (op == 6'h02) begin
      expq.push_back(PCW | src(2'b10) | DONE);
      return;
    end
    if (!(op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04})) begin
      expq.push_back('0);
      push_trap(2'b01);
      return;
    end
    if (op == 6'h00 && !(fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A})) begin
      expq.push_back('0);
      push_trap(2'b10);
      return;
    end
    expq.push_back('0);
    s = sels(op, fn);
    if (op == 6'h04) begin
      expq.push_back(s | (z ? (PCW | src(2'b01)) : '0) | DONE);
    end else if (op == 6'h23 || op == 6'h2B) begin
      w = s | DREQ | ((op == 6'h2B) ? DWE : '0);
      expq.push_back(s);
      repeat (dw) expq.push_back(w);
      expq.push_back(w | ((op == 6'h2B) ? DONE : '0));
      if (op == 6'h23) expq.push_back(s | RW | DONE);
    end else begin
      expq.push_back(s);
      expq.push_back(s | RW | DONE);
    end
  endfunction

  // Memory responder: acks a request after iw/dw wait cycles; optional stray
  // acks while no request is up. Starts within a clock-low phase.
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input int iw, input int dw, input bit spur, input int ncyc);
    int ic = 0;
    int dc = 0;
    obs.delete();
    opcode = op;
    funct  = fn;
    zero   = z;
    for (int c = 0; c < ncyc; c++) begin
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      #1;
      imem_ack = imem_req ? (ic == iw) : (spur && $urandom_range(0, 1) == 1);
      dmem_ack = dmem_req ? (dc == dw) : (spur && $urandom_range(0, 1) == 1);
      #1;
      obs.push_back(snap());
      ic = (imem_req && !imem_ack) ? ic + 1 : 0;
      dc = (dmem_req && !dmem_ack) ? dc + 1 : 0;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    n_chk++;
    if (snap() !== '0) begin
      n_fail++;
      $display("FAIL reset_low: outputs %h, required 00000", snap());
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (snap() !== '0) begin
      n_fail++;
      $display("FAIL reset_held: outputs %h, required 00000", snap());
    end
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (snap() !== IREQ) begin
      n_fail++;
      $display("FAIL reset_fetch: outputs %h, required %h", snap(), IREQ);
    end
  endtask

  task automatic test_addi();
    build(6'h08, 6'h15, 1'b0, 0, 0);
    run(6'h08, 6'h15, 1'b0, 0, 0, 1'b0, expq.size());
    n_chk++;
    if (expq.size() != 4 || obs[3] !== (ALUSRC | ctrl(4'b0010) | RW | DONE)) begin
      n_fail++;
      $display("FAIL addi_wb: len %0d cycle4 %h, required len 4 %h",
               expq.size(), obs[3], ALUSRC | ctrl(4'b0010) | RW | DONE);
    end
    for (int i = 0; i < expq.size(); i++) begin
      n_chk++;
      if (obs[i] !== expq[i]) begin
        n_fail++;
        $display("FAIL addi cycle %0d: got %h, required %h", i, obs[i], expq[i]);
      end
    end
  endtask

  task automatic test_lw_wait();
    build(6'h23, 6'h00, 1'b0, 0, 3);
    run(6'h23, 6'h00, 1'b0, 0, 3, 1'b0, expq.size());
    n_chk++;
    if (expq.size() != 8) begin
      n_fail++;
      $display("FAIL lw_len: got %0d, required 8", expq.size());
    end
    for (int i = 0; i < expq.size(); i++) begin
      n_chk++;
      if (obs[i] !== expq[i]) begin
        n_fail++;
        $display("FAIL lw_wait cycle %0d: got %h, required %h", i, obs[i], expq[i]);
      end
    end
  endtask

  task automatic test_beq();
    for (int k = 0; k < 2; k++) begin
      build(6'h04, 6'h00, (k == 0), 0, 0);
      run(6'h04, 6'h00, (k == 0), 0, 0, 1'b1, expq.size());
      for (int i = 0; i < expq.size(); i++) begin
        n_chk++;
        if (obs[i] !== expq[i]) begin
          n_fail++;
          $display("FAIL beq_z%0d cycle %0d: got %h, required %h",
                   (k == 0), i, obs[i], expq[i]);
        end
      end
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fns [2];
    fns[0] = 6'h22;
    fns[1] = 6'h01;
    for (int k = 0; k < 2; k++) begin
      build(6'h00, fns[k], 1'b0, 1, 0);
      run(6'h00, fns[k], 1'b0, 1, 0, 1'b0, expq.size());
      for (int i = 0; i < expq.size(); i++) begin
        n_chk++;
        if (obs[i] !== expq[i]) begin
          n_fail++;
          $display("FAIL rtype_f%h cycle %0d: got %h, required %h",
                   fns[k], i, obs[i], expq[i]);
        end
      end
    end
    test_reset();
  endtask

  task automatic test_illegal_opcode();
    build(6'h3F, 6'h20, 1'b0, 0, 0);
    run(6'h3F, 6'h20, 1'b0, 0, 0, 1'b1, expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      n_chk++;
      if (obs[i] !== expq[i]) begin
        n_fail++;
        $display("FAIL bad_op cycle %0d: got %h, required %h", i, obs[i], expq[i]);
      end
    end
    test_reset();
  endtask

  task automatic test_reset_mid();
    build(6'h2B, 6'h00, 1'b0, 0, 2);
    run(6'h2B, 6'h00, 1'b0, 0, 2, 1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (obs[i] !== expq[i]) begin
        n_fail++;
        $display("FAIL sw_pre_reset cycle %0d: got %h, required %h", i, obs[i], expq[i]);
      end
    end
    test_reset();
  endtask

  task automatic test_back_to_back();
    logic [5:0] rfn [5];
    logic [5:0] op, fn;
    logic       z;
    int         iw, dw, k;
    rfn[0] = 6'h20; rfn[1] = 6'h22; rfn[2] = 6'h24; rfn[3] = 6'h25; rfn[4] = 6'h2A;
    for (int n = 0; n < 30; n++) begin
      k  = $urandom_range(0, 9);
      fn = 6'($urandom);
      z  = 1'($urandom);
      iw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      case (k)
        5:       op = 6'h08;
        6:       op = 6'h23;
        7:       op = 6'h2B;
        8:       op = 6'h04;
        9:       op = 6'h02;
        default: begin op = 6'h00; fn = rfn[k]; end
      endcase
      build(op, fn, z, iw, dw);
      run(op, fn, z, iw, dw, 1'b1, expq.size());
      for (int i = 0; i < expq.size(); i++) begin
        n_chk++;
        if (obs[i] !== expq[i]) begin
          n_fail++;
          $display("FAIL rand#%0d op %h fn %h cycle %0d: got %h, required %h",
                   n, op, fn, i, obs[i], expq[i]);
        end
      end
    end
  endtask

`ifdef SEQ_MEM_TIMEOUT_EN
  task automatic test_timeout();
    build(6'h08, 6'h00, 1'b0, 1000, 0);
    run(6'h08, 6'h00, 1'b0, 1000, 0, 1'b0, expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      n_chk++;
      if (obs[i] !== expq[i]) begin
        n_fail++;
        $display("FAIL timeout cycle %0d: got %h, required %h", i, obs[i], expq[i]);
      end
    end
    test_reset();
    build(6'h08, 6'h00, 1'b0, TO - 1, 0);
    run(6'h08, 6'h00, 1'b0, TO - 1, 0, 1'b0, expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      n_chk++;
      if (obs[i] !== expq[i]) begin
        n_fail++;
        $display("FAIL ack_at_limit cycle %0d: got %h, required %h", i, obs[i], expq[i]);
      end
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_addi();
    test_lw_wait();
    test_beq();
    test_rtype();
    test_illegal_opcode();
    test_reset_mid();
    test_back_to_back();
`ifdef SEQ_MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
